i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_bus_sync.sv | 35 +++
 rtl/i2c_target.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding and bit-count constants
// used by both the target and master blocks.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_RD_FETCH,
        ST_READ,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic [3:0] BITS_PER_BYTE = 4'd8;
    localparam logic [3:0] BIT_CNT_DONE  = 4'd0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge strobes and START/STOP
// detection, all derived from the synchronized copies.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized value.
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_sh <= '1;
            sda_sh <= '1;
        end else begin
            scl_sh <= {scl_sh[1:0], scl_raw};
            sda_sh <= {sda_sh[1:0], sda_raw};
        end
    end

    assign sda      = sda_sh[1];
    assign scl_rise =  scl_sh[1] & ~scl_sh[2];
    assign scl_fall = ~scl_sh[1] &  scl_sh[2];
    assign start    =  scl_sh[1] &  scl_sh[2] &  sda_sh[2] & ~sda_sh[1];
    assign stop     =  scl_sh[1] &  scl_sh[2] & ~sda_sh[2] &  sda_sh[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer: writes emit a byte strobe,
// reads fetch each byte through a request/valid handshake while stretching SCL.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter logic [15:0] STRETCH_MAX = 16'd2000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    inout  wire        scl_io,
    inout  wire        sda_io,
    output logic [7:0] reg_addr_o,
    output logic [7:0] wdata_o,
    output logic       wr_valid_o,
    output logic       rd_req_o,
    input  logic [7:0] rdata_i,
    input  logic       rd_valid_i,
    output logic       busy_o,
    output logic       err_o
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .scl_raw (scl_io),
        .sda_raw (sda_io),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    i2c_state_e  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, tx_q, tx_d;
    logic [7:0]  reg_addr_q, reg_addr_d, wdata_q, wdata_d;
    logic [15:0] stretch_q, stretch_d;
    logic        rw_q, rw_d, sda_low_q, sda_low_d, scl_low_q, scl_low_d;
    logic        rd_req_q, rd_req_d, busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d, err_q, err_d;
    logic [7:0]  rx_byte;

    assign rx_byte = {shift_q[6:0], sda};

    // NOTE: state registers use non-blocking assignments and a synchronous
    // reset; all decisions are made in the combinational block below.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            stretch_q  <= '0;
            rw_q       <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_low_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            stretch_q  <= stretch_d;
            rw_q       <= rw_d;
            sda_low_q  <= sda_low_d;
            scl_low_q  <= scl_low_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        stretch_d  = stretch_q;
        rw_d       = rw_q;
        sda_low_d  = sda_low_q;
        scl_low_d  = scl_low_q;
        rd_req_d   = rd_req_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        err_d      = 1'b0;

        if (stop) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
            scl_low_d = 1'b0;
            rd_req_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = BITS_PER_BYTE;
            sda_low_d = 1'b0;
            scl_low_d = 1'b0;
            rd_req_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_REG, ST_WRITE: begin
                    if (scl_rise && bit_cnt_q != BIT_CNT_DONE) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        if (state_q == ST_WRITE && bit_cnt_q == 4'd1) begin
                            wdata_d    = rx_byte;
                            wr_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == BIT_CNT_DONE) begin
                        sda_low_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = shift_q[0];
                            end else begin
                                state_d   = ST_WAIT_STOP;
                                sda_low_d = 1'b0;
                                busy_d    = 1'b0;
                            end
                        end else if (state_q == ST_REG) begin
                            reg_addr_d = shift_q;
                            state_d    = ST_REG_ACK;
                        end else begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            state_d    = ST_WRITE_ACK;
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = BITS_PER_BYTE;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d   = ST_RD_FETCH;
                            rd_req_d  = 1'b1;
                            scl_low_d = 1'b1;
                            stretch_d = '0;
                        end else if (state_q == ST_ADDR_ACK) begin
                            state_d = ST_REG;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_RD_FETCH: begin
                    if (!rd_req_q) begin
                        if (scl_fall) begin
                            rd_req_d  = 1'b1;
                            scl_low_d = 1'b1;
                            stretch_d = '0;
                        end
                    end else if (rd_valid_i) begin
                        tx_d      = rdata_i;
                        sda_low_d = ~rdata_i[7];
                        rd_req_d  = 1'b0;
                        bit_cnt_d = BITS_PER_BYTE;
                        state_d   = ST_READ;
                    end else if (stretch_q == STRETCH_MAX) begin
                        err_d     = 1'b1;
                        rd_req_d  = 1'b0;
                        scl_low_d = 1'b0;
                        sda_low_d = 1'b0;
                        state_d   = ST_WAIT_STOP;
                    end else begin
                        stretch_d = stretch_q + 16'd1;
                    end
                end
                ST_READ: begin
                    // SCL is let go the cycle after the first bit is on SDA.
                    scl_low_d = 1'b0;
                    if (scl_rise && bit_cnt_q != BIT_CNT_DONE) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == BIT_CNT_DONE) begin
                            sda_low_d  = 1'b0;
                            reg_addr_d = reg_addr_q + 8'd1;
                            state_d    = ST_RD_ACK;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            sda_low_d = ~tx_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        state_d = sda ? ST_WAIT_STOP : ST_RD_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign scl_io     = scl_low_q ? 1'b0 : 1'bz;
    assign sda_io     = sda_low_q ? 1'b0 : 1'bz;
    assign reg_addr_o = reg_addr_q;
    assign wdata_o    = wdata_q;
    assign wr_valid_o = wr_valid_q;
    assign rd_req_o   = rd_req_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule
